// File: rtl/row_occupancy_tracker.sv
// Row occupancy tracker for a circular row buffer of DEPTH rows.
// Counts valid rows; variable-size pushes, wrapping span releases.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   flush               synchronous clear of count
//   wr_valid/wr_num     push request and row count
//   wr_ready            push accepted this cycle if wr_valid
//   rel_valid           release request
//   start_ptr/end_ptr   inclusive span of released rows (may wrap)
//   rel_ready           release accepted this cycle if rel_valid
//   count               registered occupancy, 0..DEPTH
//   full/empty          count == DEPTH / count == 0
//   almost_full/_empty  count >= AF_TH / count <= AE_TH
//   ovf_err/udf_err     sticky rejected push / rejected release
//   err_clr             clears error flags (and peak)
//   peak                highest count since reset/err_clr
//
// Build option: define OCC_PEAK_EN to implement the peak register;
// otherwise peak is tied to zero.
module row_occupancy_tracker #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int AF_TH = DEPTH - 2,
    parameter int AE_TH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_valid,
    input  logic [CNT_W-1:0] wr_num,
    output logic             wr_ready,
    input  logic             rel_valid,
    input  logic [PTR_W-1:0] start_ptr,
    input  logic [PTR_W-1:0] end_ptr,
    output logic             rel_ready,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             ovf_err,
    output logic             udf_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] peak
);

    // One extra bit so sums and spans never truncate.
    localparam int W = CNT_W + 1;
    localparam logic [W-1:0] DEPTH_W = W'(DEPTH);
    localparam logic [W-1:0] ONE_W   = W'(1);
    localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_TH);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic [W-1:0]     cnt_w;
    logic [W-1:0]     num_w;
    logic [W-1:0]     s_w;
    logic [W-1:0]     e_w;
    logic [W-1:0]     span;
    logic [W-1:0]     wr_sum;
    logic [W-1:0]     nxt_w;
    logic             ptr_ok;
    logic             wr_fire;
    logic             rel_fire;
    logic             ovf_set;
    logic             udf_set;
    logic             ovf_q;
    logic             udf_q;

    assign cnt_w = W'(count_q);
    assign num_w = W'(wr_num);
    assign s_w   = W'(start_ptr);
    assign e_w   = W'(end_ptr);

    // Inclusive span; a wrapped span adds DEPTH back in.
    always_comb begin
        if (e_w >= s_w) begin
            span = e_w - s_w + ONE_W;
        end else begin
            span = e_w + DEPTH_W - s_w + ONE_W;
        end
    end

    assign ptr_ok = (s_w < DEPTH_W) && (e_w < DEPTH_W);

    // Readies look only at the registered count, so a push and a
    // release in the same cycle can never push count out of range.
    assign wr_sum    = cnt_w + num_w;
    assign wr_ready  = (wr_sum <= DEPTH_W);
    assign rel_ready = ptr_ok && (span <= cnt_w);

    assign wr_fire  = wr_valid && wr_ready;
    assign rel_fire = rel_valid && rel_ready;
    assign ovf_set  = wr_valid && !wr_ready;
    assign udf_set  = rel_valid && !rel_ready;

    always_comb begin
        nxt_w = cnt_w;
        if (wr_fire) begin
            nxt_w = nxt_w + num_w;
        end
        if (rel_fire) begin
            nxt_w = nxt_w - span;
        end
        if (flush) begin
            nxt_w = '0;
        end
    end

    assign count_nxt = nxt_w[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set || (ovf_q && !err_clr);
            udf_q <= udf_set || (udf_q && !err_clr);
        end
    end

`ifdef OCC_PEAK_EN
    logic [CNT_W-1:0] peak_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else if (err_clr) begin
            peak_q <= '0;
        end else if (count_nxt > peak_q) begin
            peak_q <= count_nxt;
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

    assign count        = count_q;
    assign full         = (cnt_w == DEPTH_W);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign ovf_err      = ovf_q;
    assign udf_err      = udf_q;

endmodule

// File: tb/tb_row_occupancy_tracker.sv
// Self-checking bench for row_occupancy_tracker (DEPTH=16).
// Directed scenarios followed by randomized traffic vs a model.
module tb_row_occupancy_tracker;

    localparam int D = 16;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       wr_valid;
    logic [4:0] wr_num;
    logic       wr_ready;
    logic       rel_valid;
    logic [3:0] start_ptr;
    logic [3:0] end_ptr;
    logic       rel_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       ovf_err;
    logic       udf_err;
    logic       err_clr;
    logic [4:0] peak;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_cnt  = 0;
    int m_peak = 0;
    bit m_ovf  = 0;
    bit m_udf  = 0;
    int m_nxt;
    int m_npk;
    bit m_novf;
    bit m_nudf;
    bit m_wa;
    bit m_ra;

`ifdef OCC_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    row_occupancy_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_num       (wr_num),
        .wr_ready     (wr_ready),
        .rel_valid    (rel_valid),
        .start_ptr    (start_ptr),
        .end_ptr      (end_ptr),
        .rel_ready    (rel_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err),
        .err_clr      (err_clr),
        .peak         (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Spec-level model: span is the number of rows walked from
    // start to end around the ring, inclusive.
    task automatic model_eval();
        int s;
        int e;
        int sp;
        int add;
        int sub;
        s   = int'(start_ptr);
        e   = int'(end_ptr);
        sp  = ((e - s + D) % D) + 1;
        m_wa = (m_cnt + int'(wr_num)) <= D;
        m_ra = (s < D) && (e < D) && (sp <= m_cnt);
        add = (wr_valid && m_wa) ? int'(wr_num) : 0;
        sub = (rel_valid && m_ra) ? sp : 0;
        m_nxt = flush ? 0 : m_cnt + add - sub;
        m_novf = (wr_valid && !m_wa) || (m_ovf && !err_clr);
        m_nudf = (rel_valid && !m_ra) || (m_udf && !err_clr);
        if (!PEAK_EN || err_clr) m_npk = 0;
        else m_npk = (m_nxt > m_peak) ? m_nxt : m_peak;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        m_cnt  = m_nxt;
        m_ovf  = m_novf;
        m_udf  = m_nudf;
        m_peak = m_npk;
    endtask

    task automatic idle();
        flush     = 1'b0;
        wr_valid  = 1'b0;
        wr_num    = '0;
        rel_valid = 1'b0;
        start_ptr = '0;
        end_ptr   = '0;
        err_clr   = 1'b0;
    endtask

    task automatic push(input int n);
        idle();
        wr_valid = 1'b1;
        wr_num   = 5'(n);
    endtask

    task automatic rel(input int s, input int e);
        rel_valid = 1'b1;
        start_ptr = 4'(s);
        end_ptr   = 4'(e);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #13;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 ||
            almost_empty !== 1'b1 || full !== 1'b0 ||
            almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags cnt=%0d e=%b ae=%b f=%b af=%b req 0 1 1 0 0",
                     count, empty, almost_empty, full, almost_full);
        end
        n_checks++;
        if (ovf_err !== 1'b0 || udf_err !== 1'b0 || peak !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_errs ovf=%b udf=%b peak=%0d req 0 0 0",
                     ovf_err, udf_err, peak);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_push_release();
        push(5);
        tick();
        n_checks++;
        if (count !== 5'd5) begin
            n_fail++;
            $display("FAIL push5 count=%0d req 5", count);
        end
        idle();
        rel(3, 5);
        #1;
        n_checks++;
        if (rel_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_3_5_ready got=%b req 1", rel_ready);
        end
        tick();
        n_checks++;
        if (count !== 5'd2 || almost_empty !== 1'b1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_3_5 count=%0d ae=%b e=%b req 2 1 0",
                     count, almost_empty, empty);
        end
    endtask

    task automatic test_wrap();
        push(8);
        tick();
        n_checks++;
        if (count !== 5'd10) begin
            n_fail++;
            $display("FAIL fill10 count=%0d req 10", count);
        end
        push(3);
        rel(14, 1);
        tick();
        n_checks++;
        if (count !== 5'd9) begin
            n_fail++;
            $display("FAIL wrap_rel_push count=%0d req 9", count);
        end
    endtask

    task automatic test_overflow();
        push(6);
        tick();
        push(2);
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_ready got=%b req 0", wr_ready);
        end
        tick();
        n_checks++;
        if (count !== 5'd15 || ovf_err !== 1'b1 || almost_full !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf count=%0d ovf=%b af=%b req 15 1 1",
                     count, ovf_err, almost_full);
        end
        push(1);
        tick();
        n_checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_full count=%0d full=%b req 16 1", count, full);
        end
        push(0);
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_push_full ready=%b req 1", wr_ready);
        end
        tick();
        n_checks++;
        if (count !== 5'd16) begin
            n_fail++;
            $display("FAIL zero_push count=%0d req 16", count);
        end
    endtask

    task automatic test_underflow();
        idle();
        err_clr = 1'b1;
        rel(0, 12);
        tick();
        n_checks++;
        if (count !== 5'd3 || ovf_err !== 1'b0 || udf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rel13 count=%0d ovf=%b udf=%b req 3 0 0",
                     count, ovf_err, udf_err);
        end
        idle();
        rel(0, 3);
        #1;
        n_checks++;
        if (rel_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL udf_ready got=%b req 0", rel_ready);
        end
        tick();
        n_checks++;
        if (udf_err !== 1'b1 || count !== 5'd3) begin
            n_fail++;
            $display("FAIL udf udf=%b count=%0d req 1 3", udf_err, count);
        end
        idle();
        err_clr = 1'b1;
        rel(5, 1);
        tick();
        n_checks++;
        if (udf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL udf_set_wins udf=%b req 1", udf_err);
        end
        idle();
        rel(7, 7);
        #1;
        n_checks++;
        if (rel_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL span1_ready got=%b req 1", rel_ready);
        end
        tick();
        n_checks++;
        if (count !== 5'd2 || udf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL span1 count=%0d udf=%b req 2 1", count, udf_err);
        end
    endtask

    task automatic test_flush_peak();
        idle();
        flush   = 1'b1;
        err_clr = 1'b1;
        tick();
        n_checks++;
        if (count !== 5'd0 || peak !== 5'd0 || udf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clr count=%0d peak=%0d udf=%b req 0 0 0",
                     count, peak, udf_err);
        end
        push(12);
        tick();
        push(4);
        flush = 1'b1;
        tick();
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_push count=%0d empty=%b req 0 1", count, empty);
        end
        n_checks++;
        if (peak !== (PEAK_EN ? 5'd12 : 5'd0)) begin
            n_fail++;
            $display("FAIL peak12 peak=%0d req %0d", peak, PEAK_EN ? 12 : 0);
        end
        idle();
        err_clr = 1'b1;
        tick();
        n_checks++;
        if (peak !== 5'd0) begin
            n_fail++;
            $display("FAIL peak_clr peak=%0d req 0", peak);
        end
    endtask

    task automatic test_random();
        int s;
        for (int i = 0; i < 3000; i++) begin
            idle();
            wr_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) wr_num = 5'($urandom_range(0, 31));
            else wr_num = 5'($urandom_range(0, 6));
            rel_valid = ($urandom_range(0, 2) != 0);
            s = $urandom_range(0, D - 1);
            start_ptr = 4'(s);
            if ($urandom_range(0, 4) == 0) end_ptr = 4'($urandom_range(0, D - 1));
            else end_ptr = 4'((s + $urandom_range(0, 5)) % D);
            flush   = ($urandom_range(0, 99) == 0);
            err_clr = ($urandom_range(0, 29) == 0);
            #1;
            model_eval();
            n_checks++;
            if (wr_ready !== m_wa || rel_ready !== m_ra) begin
                n_fail++;
                $display("FAIL rnd_ready i=%0d wr=%b rel=%b req %b %b",
                         i, wr_ready, rel_ready, m_wa, m_ra);
            end
            tick();
            n_checks++;
            if (int'(count) !== m_cnt || full !== (m_cnt == D) ||
                empty !== (m_cnt == 0) ||
                almost_full !== (m_cnt >= D - 2) ||
                almost_empty !== (m_cnt <= 2)) begin
                n_fail++;
                $display("FAIL rnd_count i=%0d cnt=%0d f=%b e=%b af=%b ae=%b req cnt %0d",
                         i, count, full, empty, almost_full, almost_empty, m_cnt);
            end
            n_checks++;
            if (ovf_err !== m_ovf || udf_err !== m_udf ||
                int'(peak) !== m_peak) begin
                n_fail++;
                $display("FAIL rnd_errs i=%0d ovf=%b udf=%b pk=%0d req %b %b %0d",
                         i, ovf_err, udf_err, peak, m_ovf, m_udf, m_peak);
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_release();
        test_wrap();
        test_overflow();
        test_underflow();
        test_flush_peak();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
